// File: rtl/fft_power_spectrum.sv
// Power spectrum |X|^2 of the first NKEEP bins of each FFT frame, scaled and saturated.
// Optional FFT_PWR_SATCNT_EN adds o_sat_cnt, the saturated-bin count of the last frame.
module fft_power_spectrum #(
  parameter int IW    = 21,
  parameter int LGN   = 8,
  parameter int NKEEP = 129,
  parameter int SHIFT = 10,
  parameter int OW    = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_ce,
  input  logic            i_sync,
  input  logic [2*IW-1:0] i_result,
  output logic [OW-1:0]   o_data,
  output logic            o_valid,
  output logic            o_last,
  output logic [LGN-1:0]  o_bin,
  output logic            o_err
`ifdef FFT_PWR_SATCNT_EN
  ,
  output logic [15:0]     o_sat_cnt
`endif
);

  localparam int PW = 2*IW + 1;
  localparam int XW = (PW > OW) ? PW : OW;
  localparam logic [LGN-1:0] LASTB = LGN'(NKEEP - 1);
  localparam logic [LGN-1:0] ENDB  = '1;

  typedef enum logic [1:0] {
    IDLE,
    KEEP,
    SKIP
  } state_t;

  // Internal reset: asserts with i_reset_n, releases on a clock edge.
  logic [1:0] rs;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rs <= 2'b00;
    else            rs <= {rs[0], 1'b1};
  end

  assign rst_n = rs[1];

  state_t         state, state_n;
  logic [LGN-1:0] cnt, cnt_n;
  logic           acc, acc_last, err_set;
  logic [LGN-1:0] acc_bin;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc     = 1'b0;
    err_set = 1'b0;
    if (i_ce) begin
      if (i_sync) begin
        acc     = 1'b1;
        cnt_n   = LGN'(1);
        state_n = (NKEEP == 1) ? SKIP : KEEP;
        err_set = (state != IDLE) && (cnt != '0);
      end else begin
        unique case (state)
          IDLE: ;
          KEEP: begin
            acc   = 1'b1;
            cnt_n = cnt + LGN'(1);
            if (cnt == LASTB)
              state_n = (NKEEP == (1 << LGN)) ? KEEP : SKIP;
          end
          SKIP: begin
            cnt_n = cnt + LGN'(1);
            if (cnt == ENDB) state_n = KEEP;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  assign acc_bin  = i_sync ? '0 : cnt;
  assign acc_last = (acc_bin == LASTB);

  // Stage 1: squares of both components
  logic signed [IW-1:0]   re_s, im_s;
  logic signed [2*IW-1:0] pre_re, pre_im;
  logic [2*IW-1:0]        sq_re, sq_im;
  logic                   s1_valid, s1_last;
  logic [LGN-1:0]         s1_bin;

  assign re_s   = i_result[2*IW-1:IW];
  assign im_s   = i_result[IW-1:0];
  assign pre_re = re_s * re_s;
  assign pre_im = im_s * im_s;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_re    <= '0;
      sq_im    <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_bin   <= '0;
    end else if (i_ce) begin
      sq_re    <= unsigned'(pre_re);
      sq_im    <= unsigned'(pre_im);
      s1_valid <= acc;
      s1_last  <= acc_last;
      s1_bin   <= acc_bin;
    end
  end

  // Stage 2: sum, shift, saturate
  logic [PW-1:0] pwr;
  logic [XW-1:0] qx;
  logic          sat, s2_go;

  assign pwr   = PW'(sq_re) + PW'(sq_im);
  assign qx    = XW'(pwr) >> SHIFT;
  assign sat   = |(qx >> OW);
  assign s2_go = i_ce & s1_valid;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_bin   <= '0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= s2_go;
      o_last  <= s2_go & s1_last;
      if (s2_go) begin
        o_data <= sat ? '1 : qx[OW-1:0];
        o_bin  <= s1_bin;
      end
      if (err_set) o_err <= 1'b1;
    end
  end

`ifdef FFT_PWR_SATCNT_EN
  logic [15:0] sat_cnt, sat_sum;
  logic        sat_hit;

  assign sat_hit = s2_go & sat;
  assign sat_sum = (sat_hit && sat_cnt != 16'hFFFF) ?
                   sat_cnt + 16'd1 : sat_cnt;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt   <= '0;
      o_sat_cnt <= '0;
    end else begin
      if (acc && i_sync) sat_cnt <= '0;
      else               sat_cnt <= sat_sum;
      if (s2_go && s1_last) o_sat_cnt <= sat_sum;
    end
  end
`endif

endmodule

// File: tb/tb_fft_power_spectrum.sv
// Directed bench for fft_power_spectrum: default SHIFT=10 and a SHIFT=0 instance.
// Table of bin vectors with hand-computed powers plus resync/reset sequences.
module tb_fft_power_spectrum;

  logic        clk = 1'b0;
  logic        rst_n, ce, sync;
  logic [41:0] res;

  logic [31:0] d10, d0;
  logic        v10, v0, l10, l0, e10, e0;
  logic [7:0]  b10, b0;
`ifdef FFT_PWR_SATCNT_EN
  logic [15:0] sc10, sc0;
`endif

  always #5 clk = ~clk;

  fft_power_spectrum dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_sync(sync),
    .i_result(res), .o_data(d10), .o_valid(v10), .o_last(l10),
    .o_bin(b10), .o_err(e10)
`ifdef FFT_PWR_SATCNT_EN
    , .o_sat_cnt(sc10)
`endif
  );

  fft_power_spectrum #(.SHIFT(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_sync(sync),
    .i_result(res), .o_data(d0), .o_valid(v0), .o_last(l0),
    .o_bin(b0), .o_err(e0)
`ifdef FFT_PWR_SATCNT_EN
    , .o_sat_cnt(sc0)
`endif
  );

  typedef struct {
    logic [20:0] re;
    logic [20:0] im;
    logic [31:0] e10;
    logic [31:0] e0;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  b;
    logic        l;
    int          c;
  } out_t;

  vec_t        tab[8];
  logic [20:0] fre[256];
  logic [20:0] fim[256];
  out_t        q10[$];
  out_t        q0[$];
  int          lat[256];
  int          ce_cnt = 0;
  logic        last_ce = 1'b0;
  int          nchk = 0;
  int          nfail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (ce) ce_cnt <= ce_cnt + 1;
    last_ce <= ce;
  end

  always @(negedge clk) begin
    if (v10) begin
      q10.push_back('{d10, b10, l10, ce_cnt});
      chk("latency", 64'(ce_cnt), 64'(lat[b10]));
      chk("pulse_on_ce", 64'(last_ce), 64'd1);
    end
    if (v0) q0.push_back('{d0, b0, l0, ce_cnt});
  end

  function automatic logic [31:0] expd(int b, bit z);
    if (b < 8) return z ? tab[b].e0 : tab[b].e10;
    return 32'd0;
  endfunction

  // mode 0: ce always high, 1: ce toggles, 2: ~30% duty
  task automatic put_bin(int b, bit s, int mode);
    int gaps = 0;
    if (mode == 1) gaps = 1;
    else if (mode == 2)
      while ($urandom_range(99) >= 30 && gaps < 20) gaps++;
    repeat (gaps) begin
      @(negedge clk);
      ce   = 1'b0;
      sync = 1'b0;
      res  = {10'($urandom), $urandom};
    end
    @(negedge clk);
    ce     = 1'b1;
    sync   = s;
    res    = {fre[b], fim[b]};
    lat[b] = ce_cnt + 2;
  endtask

  task automatic frame(int nb, int mode);
    for (int b = 0; b < nb; b++) put_bin(b, b == 0, mode);
    @(negedge clk);
    ce   = 1'b0;
    sync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_out(string nm, int eb[$]);
    chk({nm, "_count"}, 64'(q10.size()), 64'(eb.size()));
    chk({nm, "_count0"}, 64'(q0.size()), 64'(eb.size()));
    for (int k = 0; k < eb.size() && k < q10.size() && k < q0.size(); k++) begin
      chk({nm, "_bin"}, 64'(q10[k].b), 64'(eb[k]));
      chk({nm, "_last"}, 64'(q10[k].l), 64'(eb[k] == 128));
      chk({nm, "_data"}, 64'(q10[k].d), 64'(expd(eb[k], 1'b0)));
      chk({nm, "_data0"}, 64'(q0[k].d), 64'(expd(eb[k], 1'b1)));
    end
  endtask

  task automatic clear_q();
    q10.delete();
    q0.delete();
  endtask

  int eb[$];

  initial begin
    tab[0] = '{21'd3, 21'd4, 32'd0, 32'd25};
    tab[1] = '{21'h100000, 21'h100000, 32'h8000_0000, 32'hFFFF_FFFF};
    tab[2] = '{21'd1000, 21'd0, 32'd976, 32'd1000000};
    tab[3] = '{21'h1FFC00, 21'd1024, 32'd2048, 32'd2097152};
    tab[4] = '{21'h0FFFFF, 21'd0, 32'd1073739776, 32'hFFFF_FFFF};
    tab[5] = '{21'h1FFFFF, 21'h1FFFFF, 32'd0, 32'd2};
    tab[6] = '{21'd65535, 21'd0, 32'd4194176, 32'hFFFE_0001};
    tab[7] = '{21'd65536, 21'd0, 32'd4194304, 32'hFFFF_FFFF};
    for (int b = 0; b < 256; b++) begin
      if (b < 8) begin
        fre[b] = tab[b].re;
        fim[b] = tab[b].im;
      end else if (b <= 128) begin
        fre[b] = '0;
        fim[b] = '0;
      end else begin
        fre[b] = 21'(b * 3);
        fim[b] = 21'(-b);
      end
      lat[b] = 0;
    end

    rst_n = 1'b0;
    ce    = 1'b0;
    sync  = 1'b0;
    res   = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(v10), 64'd0);
    chk("rst_data", 64'(d10), 64'd0);
    chk("rst_bin", 64'(b10), 64'd0);
    chk("rst_last", 64'(l10), 64'd0);
    chk("rst_err", 64'(e10), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // one frame, ce always high
    for (int b = 0; b < 129; b++) eb.push_back(b);
    frame(256, 0);
    check_out("t1", eb);
    chk("t1_err", 64'(e10), 64'd0);
`ifdef FFT_PWR_SATCNT_EN
    chk("t2_satcnt0", 64'(sc0), 64'd3);
    chk("t2_satcnt10", 64'(sc10), 64'd0);
`endif
    clear_q();

    // back-to-back frames: 127 skipped bins between bin 128 and next bin 0
    frame(256, 0);
    frame(256, 0);
    begin
      int e2[$];
      e2 = {eb, eb};
      check_out("t4", e2);
    end
    if (q10.size() > 129)
      chk("t4_gap", 64'(q10[129].c - q10[128].c), 64'd128);
    chk("t4_err", 64'(e10 | e0), 64'd0);
    clear_q();

    // ce toggling and sparse ce
    frame(256, 1);
    check_out("t3a", eb);
    clear_q();
    frame(256, 2);
    check_out("t3b", eb);
    clear_q();

    // resync at bin 50
    for (int b = 0; b < 50; b++) put_bin(b, b == 0, 0);
    chk("t5_err_before", 64'(e10), 64'd0);
    frame(256, 0);
    chk("t5_err", 64'(e10), 64'd1);
    begin
      int e5[$];
      for (int b = 0; b < 50; b++) e5.push_back(b);
      e5 = {e5, eb};
      check_out("t5", e5);
    end
    clear_q();
    frame(256, 0);
    chk("t5_err_held", 64'(e10), 64'd1);
    clear_q();

    // reset mid-frame at bin 70
    for (int b = 0; b < 70; b++) put_bin(b, b == 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    ce    = 1'b0;
    #1;
    chk("t6_valid", 64'(v10), 64'd0);
    chk("t6_data", 64'(d10), 64'd0);
    chk("t6_err", 64'(e10), 64'd0);
    chk("t6_bin", 64'(b10), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    for (int b = 71; b < 256; b++) put_bin(b, 1'b0, 0);
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_sync_out", 64'(q10.size()), 64'd0);
    clear_q();
    frame(256, 0);
    check_out("t6", eb);
    chk("t6_err_after", 64'(e10), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
